// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and widths for the bit-serial ALU
package alu_pkg;
  localparam int ALU_OP_W = 3;
  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/alu_1bit.sv
// alu_1bit: one-bit ALU slice; SUB adds inverted B with the carry seeded to 1
module alu_1bit
  import alu_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic Op0,
  input  logic Op1,
  input  logic Op2,
  output logic Result,
  output logic Cout
);
  alu_op_e op;
  logic bx;
  always_comb begin
    op = alu_op_e'({Op2, Op1, Op0});
    bx = (op == OP_SUB) ? ~B : B;
    Result = (op == OP_AND)   ? (A & B) :
             (op == OP_OR)    ? (A | B) :
             (op == OP_XOR)   ? (A ^ B) :
             (op == OP_ADD || op == OP_SUB) ? (A ^ bx ^ Cin) :
             (op == OP_NOTA)  ? ~A :
             (op == OP_PASSA) ? A : B;
    Cout = (op == OP_ADD || op == OP_SUB) ? ((A & bx) | (A & Cin) | (bx & Cin)) : 1'b0;
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer, LSB first, one bit per clock
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [WIDTH-1:0]    req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e           state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q, s_res, s_cout;
  logic [CW-1:0]    cnt;
  alu_1bit u_slice (
    .A      (a_q[0]),
    .B      (b_q[0]),
    .Cin    (carry_q),
    .Op0    (op_q[0]),
    .Op1    (op_q[1]),
    .Op2    (op_q[2]),
    .Result (s_res),
    .Cout   (s_cout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          state   <= S_RUN;
          op_q    <= alu_op_e'(req_op);
          a_q     <= req_a;
          b_q     <= req_b;
          carry_q <= (alu_op_e'(req_op) == OP_SUB);
          cnt     <= '0;
        end
        S_RUN: begin
          res_q   <= {s_res, res_q[WIDTH-1:1]};
          carry_q <= s_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    req_ready  = (state == S_IDLE);
    rsp_valid  = (state == S_DONE);
    rsp_result = res_q;
    rsp_carry  = (op_q == OP_ADD || op_q == OP_SUB) && carry_q;
    rsp_zero   = (res_q == '0);
  end
endmodule
